// File: rtl/dbg_pkg.sv
// Shared constants, state encoding and helpers for the debugger data-memory bridge.
package dbg_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned RSP_CNT_W      = 3;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StAddrHi = 3'd1;
  localparam state_t StAddrLo = 3'd2;
  localparam state_t StData   = 3'd3;
  localparam state_t StMemWr  = 3'd4;
  localparam state_t StMemRd  = 3'd5;
  localparam state_t StResp   = 3'd6;
  localparam state_t StErr    = 3'd7;

  typedef enum logic {OpRd, OpWr} op_e;

  typedef logic [RSP_CNT_W-1:0] rsp_cnt_t;

  // Single-byte responses sit in the top byte so they leave the shifter first.
  function automatic logic [DATA_W-1:0] rsp_byte_word(input logic [7:0] b);
    return {b, {(DATA_W - 8){1'b0}}};
  endfunction

endpackage

// File: rtl/dbg_dmem_bridge_if.sv
// UART byte stream, response stream and data-memory port-2 signals of the bridge.
interface dbg_dmem_bridge_if
  import dbg_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic              i_rx_valid;
  logic [7:0]        i_rx_data;
  logic              o_tx_valid;
  logic [7:0]        o_tx_data;
  logic              i_tx_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_write;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy;
  logic              o_rx_drop;

  modport master (
    input  i_rx_valid,
    input  i_rx_data,
    input  i_tx_ready,
    input  i_mem_rdata,
    output o_tx_valid,
    output o_tx_data,
    output o_mem_addr,
    output o_mem_write,
    output o_mem_wdata,
    output o_busy,
    output o_rx_drop
  );

  modport slave (
    output i_rx_valid,
    output i_rx_data,
    output i_tx_ready,
    output i_mem_rdata,
    input  o_tx_valid,
    input  o_tx_data,
    input  o_mem_addr,
    input  o_mem_write,
    input  o_mem_wdata,
    input  o_busy,
    input  o_rx_drop
  );

endinterface

// File: rtl/dbg_resp_shifter.sv
// Response buffer: loads up to one word, presents its top byte and shifts on each handshake.
module dbg_resp_shifter
  import dbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  rsp_cnt_t          load_cnt,
  input  logic              ready,
  output logic              valid,
  output logic [7:0]        data,
  output logic              last
);

  logic [DATA_W-1:0] buf_q, buf_d;
  rsp_cnt_t          cnt_q, cnt_d;

  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (load) begin
      buf_d = load_data;
      cnt_d = load_cnt;
    end else if (valid && ready) begin
      buf_d = {buf_q[DATA_W-9:0], 8'h00};
      cnt_d = cnt_q - rsp_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid = (cnt_q != '0);
  assign last  = (cnt_q == rsp_cnt_t'(1));
  assign data  = buf_q[DATA_W-1 -: 8];

endmodule

// File: rtl/dbg_dmem_bridge.sv
// Debugger command engine: parses UART bytes into single-word reads/writes on
// data-memory port 2 and streams the response bytes back to the transmitter.
module dbg_dmem_bridge
  import dbg_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  dbg_dmem_bridge_if.master bus
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  op_e               op_q, op_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;

  logic              accepting;
  logic              rx_take;
  logic              tmo_hit;
  logic              rsp_load;
  logic [DATA_W-1:0] rsp_word;
  rsp_cnt_t          rsp_cnt;
  logic              rsp_valid;
  logic              rsp_last;
  logic [7:0]        rsp_byte;

  assign accepting = (state_q == StIdle) || (state_q == StAddrHi) ||
                     (state_q == StAddrLo) || (state_q == StData);
  assign rx_take   = bus.i_rx_valid && accepting;
  assign tmo_hit   = (tmo_q == TmoLast);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    hi_d     = hi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    tmo_d    = '0;
    rsp_load = 1'b0;
    rsp_word = '0;
    rsp_cnt  = '0;

    unique case (state_q)
      StIdle: begin
        if (rx_take) begin
          if (bus.i_rx_data == CMD_WR) begin
            op_d    = OpWr;
            state_d = StAddrHi;
          end else if (bus.i_rx_data == CMD_RD) begin
            op_d    = OpRd;
            state_d = StAddrHi;
          end else begin
            state_d = StErr;
          end
        end
      end
      StAddrHi: begin
        if (rx_take) begin
          hi_d    = bus.i_rx_data;
          state_d = StAddrLo;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StAddrLo: begin
        if (rx_take) begin
          // Upper address bits beyond ADDR_W are dropped silently.
          addr_d  = ADDR_W'({hi_q, bus.i_rx_data});
          cnt_d   = '0;
          state_d = (op_q == OpWr) ? StData : StMemRd;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StData: begin
        if (rx_take) begin
          wdata_d = {wdata_q[DATA_W-9:0], bus.i_rx_data};
          if (cnt_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = StMemWr;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StMemWr: begin
        rsp_load = 1'b1;
        rsp_word = rsp_byte_word(RSP_ACK);
        rsp_cnt  = rsp_cnt_t'(1);
        state_d  = StResp;
      end
      StMemRd: begin
        rsp_load = 1'b1;
        rsp_word = bus.i_mem_rdata;
        rsp_cnt  = rsp_cnt_t'(BYTES_PER_WORD);
        state_d  = StResp;
      end
      StErr: begin
        rsp_load = 1'b1;
        rsp_word = rsp_byte_word(RSP_ERR);
        rsp_cnt  = rsp_cnt_t'(1);
        state_d  = StResp;
      end
      StResp: begin
        if (!rsp_valid || (bus.i_tx_ready && rsp_last)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      op_q    <= OpRd;
      hi_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  dbg_resp_shifter u_resp_shifter (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .load      (rsp_load),
    .load_data (rsp_word),
    .load_cnt  (rsp_cnt),
    .ready     (bus.i_tx_ready),
    .valid     (rsp_valid),
    .data      (rsp_byte),
    .last      (rsp_last)
  );

  assign bus.o_tx_valid  = rsp_valid;
  assign bus.o_tx_data   = rsp_byte;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_write = (state_q == StMemWr);
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_busy      = (state_q != StIdle);
  assign bus.o_rx_drop   = bus.i_rx_valid && !accepting;

endmodule

// File: tb/tb_dbg_dmem_bridge.sv
// Directed bench for dbg_dmem_bridge with a small word-memory model and a tx byte collector.
module tb_dbg_dmem_bridge;

  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dbg_dmem_bridge_if #(.ADDR_W(AW)) bus ();

  dbg_dmem_bridge #(
    .ADDR_W         (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  logic [31:0] mem   [0:(1<<AW)-1];
  logic        mem_v [0:(1<<AW)-1] = '{default: 1'b0};
  int unsigned wr_cnt = 0;
  logic [7:0]  txq [$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  // Unwritten words read as a recognisable address-derived pattern.
  function automatic logic [31:0] init_word(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  assign bus.i_mem_rdata = mem_v[bus.o_mem_addr] ? mem[bus.o_mem_addr]
                                                 : init_word(bus.o_mem_addr);

  always @(posedge clk) begin
    if (bus.o_mem_write) begin
      mem[bus.o_mem_addr]   <= bus.o_mem_wdata;
      mem_v[bus.o_mem_addr] <= 1'b1;
      wr_cnt                <= wr_cnt + 1;
    end
    if (bus.o_tx_valid && bus.i_tx_ready) txq.push_back(bus.o_tx_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    tick(1);
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && bus.o_busy; i++) tick(1);
    check_eq({tag, "_idle"}, 32'(bus.o_busy), 32'd0);
  endtask

  // Compares the collected tx bytes against the top n bytes of word, then clears them.
  task automatic check_tx(input string tag, input logic [31:0] word, input int n);
    check_eq({tag, "_len"}, 32'(txq.size()), 32'(n));
    for (int i = 0; i < n && i < txq.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(txq[i]), 32'(word[31-8*i -: 8]));
    end
    txq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    bus.i_tx_ready = 1'b1;

    // Asynchronous reset, observed before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_busy",  32'(bus.o_busy),      32'd0);
    check_eq("rst_txv",   32'(bus.o_tx_valid),  32'd0);
    check_eq("rst_txd",   32'(bus.o_tx_data),   32'd0);
    check_eq("rst_we",    32'(bus.o_mem_write), 32'd0);
    check_eq("rst_addr",  32'(bus.o_mem_addr),  32'd0);
    check_eq("rst_wdata", bus.o_mem_wdata,      32'd0);
    check_eq("rst_drop",  32'(bus.o_rx_drop),   32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Write 0xDEADBEEF to 0x012.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check_eq("wr_we",    32'(bus.o_mem_write), 32'd1);
    check_eq("wr_addr",  32'(bus.o_mem_addr),  32'h012);
    check_eq("wr_wdata", bus.o_mem_wdata,      32'hDEADBEEF);
    check_eq("wr_txv0",  32'(bus.o_tx_valid),  32'd0);
    tick(1);
    check_eq("wr_we_off", 32'(bus.o_mem_write), 32'd0);
    check_eq("wr_txv1",   32'(bus.o_tx_valid),  32'd1);
    check_eq("wr_ack",    32'(bus.o_tx_data),   32'h4B);
    tick(1);
    check_eq("wr_busy", 32'(bus.o_busy),     32'd0);
    check_eq("wr_txv2", 32'(bus.o_tx_valid), 32'd0);
    check_eq("wr_cnt",  32'(wr_cnt),         32'd1);
    check_tx("wr_rsp", 32'h4B00_0000, 1);

    // Read back with a 5-cycle stall and a dropped byte mid-stall.
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h12);
    check_eq("rd_busy", 32'(bus.o_busy),      32'd1);
    check_eq("rd_addr", 32'(bus.o_mem_addr),  32'h012);
    check_eq("rd_txv0", 32'(bus.o_tx_valid),  32'd0);
    check_eq("rd_we",   32'(bus.o_mem_write), 32'd0);
    tick(1);
    check_eq("rd_txv1", 32'(bus.o_tx_valid), 32'd1);
    check_eq("rd_b0",   32'(bus.o_tx_data),  32'hDE);
    tick(1);
    check_eq("rd_b1", 32'(bus.o_tx_data), 32'hAD);
    bus.i_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = 8'h57;
        #1;
        check_eq("drop_pulse", 32'(bus.o_rx_drop), 32'd1);
      end
      tick(1);
      bus.i_rx_valid = 1'b0;
      bus.i_rx_data  = 8'h00;
      check_eq($sformatf("stall_d%0d", i), 32'(bus.o_tx_data),  32'hAD);
      check_eq($sformatf("stall_v%0d", i), 32'(bus.o_tx_valid), 32'd1);
    end
    check_eq("drop_clear", 32'(bus.o_rx_drop), 32'd0);
    bus.i_tx_ready = 1'b1;
    wait_idle("rd");
    check_tx("rd_rsp", 32'hDEADBEEF, 4);
    check_eq("rd_wr_cnt", 32'(wr_cnt), 32'd1);

    // Address truncation: 0xFC05 -> 0x005.
    send_byte(8'h52); send_byte(8'hFC); send_byte(8'h05);
    check_eq("trunc_addr", 32'(bus.o_mem_addr), 32'h005);
    wait_idle("trunc");
    check_tx("trunc_rsp", 32'hC0DE0005, 4);

    // Invalid command byte.
    send_byte(8'h41);
    check_eq("err_busy", 32'(bus.o_busy),     32'd1);
    check_eq("err_txv0", 32'(bus.o_tx_valid), 32'd0);
    tick(1);
    check_eq("err_txv1", 32'(bus.o_tx_valid), 32'd1);
    check_eq("err_byte", 32'(bus.o_tx_data),  32'h3F);
    wait_idle("err");
    check_tx("err_rsp", 32'h3F00_0000, 1);
    check_eq("err_wr_cnt", 32'(wr_cnt), 32'd1);

    // Timeout after 57,00 then silence.
    send_byte(8'h57); send_byte(8'h00);
    tick(TMO - 1);
    check_eq("tmo_pre_busy", 32'(bus.o_busy), 32'd1);
    tick(1);
    check_eq("tmo_busy",   32'(bus.o_busy),     32'd0);
    check_eq("tmo_txv",    32'(bus.o_tx_valid), 32'd0);
    check_eq("tmo_wr_cnt", 32'(wr_cnt),         32'd1);
    check_tx("tmo_rsp", 32'h0, 0);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_idle("post_tmo");
    check_tx("post_tmo_rsp", 32'hC0DE0000, 4);

    // Reset in the middle of the data phase.
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h11); send_byte(8'h22);
    check_eq("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy",  32'(bus.o_busy),      32'd0);
    check_eq("mid_rst_addr",  32'(bus.o_mem_addr),  32'd0);
    check_eq("mid_rst_wdata", bus.o_mem_wdata,      32'd0);
    check_eq("mid_rst_we",    32'(bus.o_mem_write), 32'd0);
    check_eq("mid_rst_txv",   32'(bus.o_tx_valid),  32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check_eq("post_rst_busy",   32'(bus.o_busy), 32'd0);
    check_eq("post_rst_wr_cnt", 32'(wr_cnt),     32'd1);
    check_tx("post_rst_rsp", 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
